regfile_access_ctrl: RTL

//  Owns the write port and a debug read port of the 32x32 register file. After reset it

---
 rtl/regfile_access_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file write/debug-read port controller: post-reset clear of x1..x31, then
// arbitration between pipeline writeback (priority) and a debug requester with stall escalation.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | clearing x1..x31 one per cycle, pipeline stalled, debug blocked
// ST_RUN   | normal arbitration, writeback first, debug on idle cycles
// ST_STALL | debug starved for MAX_WAIT cycles, pipeline frozen until granted
module regfile_access_ctrl #(
  parameter int XLEN           = 32,
  parameter int MAX_WAIT       = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [4:0]      dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic [4:0]      rf_raddr_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  output logic            stall_o,
  output logic            init_done_o
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam logic [4:0] LAST_REG = 5'd31;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e          state_q, state_d;
  logic [4:0]      clr_ptr_q, clr_ptr_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            init_done_q, init_done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST_STATE;
      clr_ptr_q   <= 5'd1;
      wait_cnt_q  <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    dbg_gnt_o   = 1'b0;
    rf_we_o     = 1'b0;
    rf_waddr_o  = wb_rd_i;
    rf_wdata_o  = wb_data_i;
    stall_o     = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        stall_o    = 1'b1;
        rf_we_o    = 1'b1;
        rf_waddr_o = clr_ptr_q;
        rf_wdata_o = '0;
        clr_ptr_d  = clr_ptr_q + 5'd1;
        wait_cnt_d = '0;
        if (clr_ptr_q == LAST_REG) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end

      ST_RUN, ST_STALL: begin
        stall_o     = (state_q == ST_STALL);
        init_done_d = 1'b1;
        if (wb_we_i) begin
          // x0 is hardwired; the write is swallowed here rather than in the RF
          rf_we_o = (wb_rd_i != 5'd0);
        end else if (dbg_req_i) begin
          dbg_gnt_o  = 1'b1;
          rf_we_o    = dbg_we_i && (dbg_addr_i != 5'd0);
          rf_waddr_o = dbg_addr_i;
          rf_wdata_o = dbg_wdata_i;
          if (!dbg_we_i) begin
            rvalid_d = 1'b1;
            rdata_d  = rf_rdata_i;
          end
        end

        if (dbg_req_i && !dbg_gnt_o) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
          wait_cnt_d = '0;
        end

        state_d = (wait_cnt_d == WAIT_MAX) ? ST_STALL : ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign rf_raddr_o   = dbg_addr_i;
  assign dbg_rvalid_o = rvalid_q;
  assign dbg_rdata_o  = rdata_q;
  assign init_done_o  = init_done_q;

endmodule
